// File: rtl/par_2_ser_shift_reg.sv
// LSB-first parallel-to-serial converter: din_en loads a word, otherwise the
// register shifts right with zero fill, and bit 0 is presented on dout[0].
module par_2_ser_shift_reg #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_en,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] shift_in;
  logic [DATA_WIDTH-1:0] shift_in_d;

  // A load always wins, so a new word pre-empts whatever is still unsent.
  always_comb begin
    shift_in_d = shift_in >> 1;
    if (din_en) begin
      shift_in_d = din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_in <= '0;
    end else begin
      shift_in <= shift_in_d;
    end
  end

  assign dout = {{(DATA_WIDTH-1){1'b0}}, shift_in[0]};

endmodule

// File: tb/tb_par_2_ser_shift_reg.sv
// Randomized and directed bench for par_2_ser_shift_reg, checked against a
// word/shift-count model of the serializer.
module tb_par_2_ser_shift_reg;
  localparam int W = 4;

  logic         clk;
  logic         resetn;
  logic [W-1:0] din;
  logic         din_en;
  logic [W-1:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: last loaded word and number of shifts performed since that load.
  int m_word  = 0;
  int m_shift = W;

  par_2_ser_shift_reg #(.DATA_WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .din    (din),
    .din_en (din_en),
    .dout   (dout)
  );

  initial begin
    clk = 1'b0;
    #3;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_sr();
    if (m_shift >= W) return 0;
    return m_word / (1 << m_shift);
  endfunction

  function automatic int exp_bit();
    return exp_sr() % 2;
  endfunction

  task automatic check_model(input string tag);
    check_eq({tag, ".shift_in"}, int'(dut.shift_in), exp_sr());
    check_eq({tag, ".dout"}, int'(dout), exp_bit());
    $display("txn %s: din_en=%0b din=%0d shift_in=%0d dout=%0d", tag, din_en, din, dut.shift_in, dout);
  endtask

  // One clock with the given inputs; sample 2 ns after the edge.
  task automatic step(input string tag, input logic en, input logic [W-1:0] d);
    din_en = en;
    din    = d;
    @(posedge clk);
    if (en) begin
      m_word  = int'(d);
      m_shift = 0;
    end else if (m_shift < W) begin
      m_shift++;
    end
    #2;
    check_model(tag);
  endtask

  // Assert reset between edges, confirm immediate clear, hold across an edge
  // with din_en high, then release between edges.
  task automatic mid_reset(input string tag);
    #1;
    resetn = 1'b0;
    #1;
    m_word  = 0;
    m_shift = W;
    check_eq({tag, ".async_sr"}, int'(dut.shift_in), 0);
    check_eq({tag, ".async_dout"}, int'(dout), 0);
    din_en = 1'b1;
    din    = W'($urandom);
    @(posedge clk);
    #1;
    check_eq({tag, ".ignore_en"}, int'(dut.shift_in), 0);
    @(negedge clk);
    din_en = 1'b0;
    resetn = 1'b1;
  endtask

  logic [W-1:0] exp_a [5];
  logic [W-1:0] v;

  initial begin
    resetn = 1'b0;
    din    = '0;
    din_en = 1'b0;
    #10;
    check_eq("rst.sr", int'(dut.shift_in), 0);
    check_eq("rst.dout", int'(dout), 0);
    #5;
    resetn = 1'b1;
    step("post_rst", 1'b0, 4'b1111);
    check_eq("post_rst.dout", int'(dout), 0);

    // Load 1010 then four shifts.
    exp_a[0] = 4'b1010; exp_a[1] = 4'b0101; exp_a[2] = 4'b0010;
    exp_a[3] = 4'b0001; exp_a[4] = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step("ld1010", i == 0, i == 0 ? 4'b1010 : 4'b0111);
      check_eq("ld1010.lit_sr", int'(dut.shift_in), int'(exp_a[i]));
      v = exp_a[i];
      check_eq("ld1010.lit_bit", int'(dout), int'(v[0]));
    end
    step("idle", 1'b0, 4'b1111);
    check_eq("idle.lit", int'(dout), 0);

    // Reset mid-stream after load + 2 shifts.
    step("mid_ld", 1'b1, 4'b1010);
    step("mid_s1", 1'b0, 4'b0000);
    step("mid_s2", 1'b0, 4'b0000);
    mid_reset("midrst");

    // Reload 1100 after reset.
    for (int i = 0; i < 5; i++) begin
      step("ld1100", i == 0, 4'b1100);
      v = 4'b1100 >> i;
      check_eq("ld1100.lit_bit", int'(dout), int'(v[0]));
    end

    // din_en held high three cycles with 0001.
    for (int i = 0; i < 3; i++) begin
      step("cont", 1'b1, 4'b0001);
      check_eq("cont.lit", int'(dout), 1);
    end
    step("cont_sh", 1'b0, 4'b0001);
    check_eq("cont_sh.lit", int'(dout), 0);

    // Pre-emption: 1111, one shift, then load 0010.
    step("pre_ld", 1'b1, 4'b1111);
    step("pre_s", 1'b0, 4'b0000);
    step("pre_ld2", 1'b1, 4'b0010);
    check_eq("pre.lit_sr", int'(dut.shift_in), 2);
    check_eq("pre.b0", int'(dout), 0);
    step("pre_s1", 1'b0, 4'b1111);
    check_eq("pre.b1", int'(dout), 1);
    step("pre_s2", 1'b0, 4'b1111);
    check_eq("pre.b2", int'(dout), 0);
    step("pre_s3", 1'b0, 4'b1111);
    check_eq("pre.b3", int'(dout), 0);

    // Random traffic with occasional asynchronous reset.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        mid_reset("rnd_rst");
      end
      step("rnd", $urandom_range(0, 3) == 0, W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/par_2_ser_shift_reg.md
PAR_2_SER_SHIFT_REG -- requirements
Module: par_2_ser_shift_reg

Interface
REQ-001 Parameter: DATA_WIDTH, default 4, parallel word width in bits (legal range >= 2).
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: resetn  input  1  asynchronous, active-low reset.
REQ-004 Port: din  input  DATA_WIDTH  parallel data word to be serialized.
REQ-005 Port: din_en  input  1  load strobe; when high, din is captured at the next rising clk edge.
REQ-006 Port: dout  output  DATA_WIDTH  serial output; bit 0 carries the current serial bit, and bits DATA_WIDTH-1..1 SHALL be constant 0.

Function
REQ-007 The block SHALL hold a DATA_WIDTH-bit internal register named shift_in, visible by hierarchical reference for verification.
REQ-008 On a rising clk edge with resetn high and din_en high, shift_in SHALL load din.
REQ-009 On a rising clk edge with resetn high and din_en low, shift_in SHALL shift right by one bit, with 0 entering the MSB.
REQ-010 dout[0] SHALL equal shift_in[0] combinationally, with no extra register stage.
REQ-011 Serialization order SHALL be LSB first: after a load of din, successive cycles present din[0], din[1], ..., din[DATA_WIDTH-1], then 0 indefinitely.
REQ-012 Latency: din[0] SHALL appear on dout[0] immediately after the loading clock edge.
REQ-013 Each following bit SHALL appear one clock later than the previous bit.
REQ-014 din_en held high for several cycles SHALL reload din on every such edge, so dout[0] stays at the current din[0].
REQ-015 Asserting din_en mid-serialization SHALL discard the remaining unsent bits and load the new din on that edge.
REQ-016 After DATA_WIDTH shifts with no load, shift_in SHALL be all zeros and SHALL remain zero until the next load.
REQ-017 The register SHALL not wrap around or recirculate.
REQ-018 din SHALL be ignored whenever din_en is low.
REQ-019 No handshake, busy or valid output exists; the upstream source is responsible for spacing loads at least DATA_WIDTH cycles apart if every bit must be transmitted.

Reset
REQ-020 While resetn is low, shift_in SHALL be cleared to all zeros immediately, independent of clk, so dout SHALL read 0.
REQ-021 While resetn is low, din_en SHALL be ignored.
REQ-022 Reset asserted mid-serialization SHALL abort the word; no partial data SHALL survive reset.
REQ-023 On the first rising clk edge after resetn deasserts, normal load/shift operation SHALL resume.

Structure
REQ-024 No shared package is required; DATA_WIDTH is the only constant and SHALL be a module parameter.
REQ-025 The block SHALL be a single module with no sub-modules: one sequential process for shift_in and one continuous assignment for dout.

Verification
REQ-026 Reset release: hold resetn=0 for 15 ns, then release with din_en=0 -> shift_in=0000 and dout=0000 throughout reset and afterwards.
REQ-027 Load 1010: DATA_WIDTH=4, din=4'b1010, din_en pulsed high for one cycle -> shift_in sequence 1010, 0101, 0010, 0001, 0000 and dout[0] sequence 0, 1, 0, 1, 0, then dout stays 0.
REQ-028 Reset mid-stream: load 1010, shift 2 cycles, assert resetn=0 between clock edges -> shift_in=0000 immediately without waiting for a clock edge.
REQ-029 Reload after reset: release reset, din=4'b1100, one-cycle din_en -> dout[0] sequence 0, 0, 1, 1, 0.
REQ-030 Continuous load: din_en held high 3 cycles with din=4'b0001 -> dout[0]=1 on every one of those cycles, then 0 after the first shift.
REQ-031 Preemption: load 4'b1111, shift 1 cycle, then one-cycle load of 4'b0010 -> shift_in=0010 and dout[0] sequence 0, 1, 0, 0.
